// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window controller and its line buffer.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int IMG_W_DEF   = 64;
    localparam int IMG_H_DEF   = 64;
    localparam int ADD_LAT_DEF = 2;
    localparam int PIX_W_DEF   = 8;

    // Window register slots; rows run top to bottom, columns left to right.
    localparam int NTAPS  = 9;
    localparam int TAP_C1 = 0;
    localparam int TAP_C2 = 1;
    localparam int TAP_C3 = 2;
    localparam int TAP_C4 = 3;
    localparam int TAP_C5 = 4;
    localparam int TAP_C6 = 5;
    localparam int TAP_C7 = 6;
    localparam int TAP_C8 = 7;
    localparam int TAP_C9 = 8;

endpackage

// File: rtl/conv_linebuf.sv
// Two-row line buffer: reads top/mid at addr, then shifts mid up and pix into mid.
module conv_linebuf #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [PIX_W-1:0] top_o,
    output logic [PIX_W-1:0] mid_o
);

    logic [PIX_W-1:0] lb0_q [DEPTH];
    logic [PIX_W-1:0] lb1_q [DEPTH];

    // Asynchronous read gives the pre-write contents in the accept cycle.
    assign top_o = lb1_q[addr_i];
    assign mid_o = lb0_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            lb1_q[addr_i] <= lb0_q[addr_i];
            lb0_q[addr_i] <= pix_i;
        end
    end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Raster-to-3x3 window sequencer feeding the 9-operand adder stage, with border
// suppression, adder-latency-aligned sum_valid and frame start/end control.
module conv3x3_window_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] c1,
    output logic [PIX_W-1:0] c2,
    output logic [PIX_W-1:0] c3,
    output logic [PIX_W-1:0] c4,
    output logic [PIX_W-1:0] c5,
    output logic [PIX_W-1:0] c6,
    output logic [PIX_W-1:0] c7,
    output logic [PIX_W-1:0] c8,
    output logic [PIX_W-1:0] c9,
    output logic             win_valid,
    output logic             sum_valid,
    output logic [15:0]      win_row,
    output logic [15:0]      win_col,
    output logic             busy,
    output logic             frame_done
);

    localparam int AW = $clog2(IMG_W);

    state_e           state_q, state_d;
    logic [15:0]      row_q, row_d;
    logic [15:0]      col_q, col_d;
    logic [15:0]      dcnt_q, dcnt_d;
    logic [PIX_W-1:0] win_q [NTAPS];
    logic             win_valid_q;
    logic [15:0]      win_row_q, win_col_q;
    logic [ADD_LAT-1:0] sum_pipe_q;
    logic [PIX_W-1:0] top, mid;
    logic             accept, col_wrap, last_px, full_win;

    assign accept   = pix_valid & pix_ready;
    assign col_wrap = (col_q == 16'(IMG_W - 1));
    assign last_px  = col_wrap && (row_q == 16'(IMG_H - 1));
    assign full_win = (row_q >= 16'd2) && (col_q >= 16'd2);

    conv_linebuf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_linebuf (
        .clk    (clk),
        .we_i   (accept),
        .addr_i (col_q[AW-1:0]),
        .pix_i  (pix_in),
        .top_o  (top),
        .mid_o  (mid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        dcnt_d     = dcnt_q;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_FILL, ST_RUN: begin
                pix_ready = 1'b1;
                if (accept) begin
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (state_q == ST_FILL && row_q == 16'd1) state_d = ST_RUN;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (last_px) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = 16'(ADD_LAT);
                    end
                end
            end
            ST_DRAIN: begin
                // Counter hits zero in the cycle the last sum_valid is out.
                if (dcnt_q == 16'd0) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) win_q[i] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]   <= win_q[3*r+1];
                win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[TAP_C3] <= top;
            win_q[TAP_C6] <= mid;
            win_q[TAP_C9] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= accept && full_win;
            if (accept && full_win) begin
                win_row_q <= row_q;
                win_col_q <= col_q;
            end
        end
    end

    // Free-running: the adder stage never stalls, so neither does this.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_pipe_q <= '0;
        end else begin
            sum_pipe_q[0] <= win_valid_q;
            for (int i = 1; i < ADD_LAT; i++) sum_pipe_q[i] <= sum_pipe_q[i-1];
        end
    end

    assign c1        = win_q[TAP_C1];
    assign c2        = win_q[TAP_C2];
    assign c3        = win_q[TAP_C3];
    assign c4        = win_q[TAP_C4];
    assign c5        = win_q[TAP_C5];
    assign c6        = win_q[TAP_C6];
    assign c7        = win_q[TAP_C7];
    assign c8        = win_q[TAP_C8];
    assign c9        = win_q[TAP_C9];
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign sum_valid = sum_pipe_q[ADD_LAT-1];
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Directed/randomized bench: 4x4 instance checked against a frame-array window model, plus a 3x3 instance.
module tb_conv3x3_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_in = '0;

    logic a_pix_ready, a_win_valid, a_sum_valid, a_busy, a_frame_done;
    logic [7:0] a_c1, a_c2, a_c3, a_c4, a_c5, a_c6, a_c7, a_c8, a_c9;
    logic [15:0] a_win_row, a_win_col;
    logic b_pix_ready, b_win_valid, b_sum_valid, b_busy, b_frame_done;
    logic [7:0] b_c1, b_c2, b_c3, b_c4, b_c5, b_c6, b_c7, b_c8, b_c9;
    logic [15:0] b_win_row, b_win_col;

    always #5 clk = ~clk;

    conv3x3_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADD_LAT(L)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(a_pix_ready), .c1(a_c1), .c2(a_c2), .c3(a_c3), .c4(a_c4), .c5(a_c5),
        .c6(a_c6), .c7(a_c7), .c8(a_c8), .c9(a_c9), .win_valid(a_win_valid),
        .sum_valid(a_sum_valid), .win_row(a_win_row), .win_col(a_win_col),
        .busy(a_busy), .frame_done(a_frame_done));

    conv3x3_window_ctrl #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .ADD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(b_pix_ready), .c1(b_c1), .c2(b_c2), .c3(b_c3), .c4(b_c4), .c5(b_c5),
        .c6(b_c6), .c7(b_c7), .c8(b_c8), .c9(b_c9), .win_valid(b_win_valid),
        .sum_valid(b_sum_valid), .win_row(b_win_row), .win_col(b_win_col),
        .busy(b_busy), .frame_done(b_frame_done));

    logic [8:0][7:0] a_taps, b_taps;
    assign a_taps = {a_c9, a_c8, a_c7, a_c6, a_c5, a_c4, a_c3, a_c2, a_c1};
    assign b_taps = {b_c9, b_c8, b_c7, b_c6, b_c5, b_c4, b_c3, b_c2, b_c1};

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pix [16];

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log for instance A: {taps, row, col} per window plus event cycles.
    logic [103:0] win_q [$];
    int win_cyc_q [$];
    int sum_cyc_q [$];
    int done_cyc_q [$];
    int acc_cyc_q [$];
    int glitch = 0;
    logic prev_acc = 1'b0;
    logic [8:0][7:0] prev_taps = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_acc  <= 1'b0;
            prev_taps <= '0;
        end else begin
            if (a_win_valid) begin
                win_q.push_back({a_taps, a_win_row, a_win_col});
                win_cyc_q.push_back(cyc);
                if (!prev_acc) glitch <= glitch + 1;
            end
            if (!prev_acc && a_taps !== prev_taps) glitch <= glitch + 1;
            if (a_sum_valid) sum_cyc_q.push_back(cyc);
            if (a_frame_done) done_cyc_q.push_back(cyc);
            if (pix_valid && a_pix_ready) acc_cyc_q.push_back(cyc);
            prev_acc  <= pix_valid && a_pix_ready;
            prev_taps <= a_taps;
        end
    end

    int b_wins = 0, b_sums = 0, b_win_cyc = -1, b_sum_cyc = -1, b_done_cyc = -1, b_acc_last = -1;
    logic [8:0][7:0] b_taps_cap = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (b_win_valid) begin
                b_wins     <= b_wins + 1;
                b_win_cyc  <= cyc;
                b_taps_cap <= b_taps;
            end
            if (b_sum_valid) begin
                b_sums    <= b_sums + 1;
                b_sum_cyc <= cyc;
            end
            if (b_frame_done) b_done_cyc <= cyc;
            if (pix_valid && b_pix_ready) b_acc_last <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        win_q.delete();
        win_cyc_q.delete();
        sum_cyc_q.delete();
        done_cyc_q.delete();
        acc_cyc_q.delete();
        glitch = 0;
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < 16; i++) pix[i] = base + i + 1;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) pix[i] = int'($urandom_range(1, 255));
    endtask

    task automatic start_frame(input bit to_b);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // mode 0: continuous, 1: valid on alternate cycles, 2: random gaps
    task automatic send(input bit to_b, input int n, input int mode, input int mid_start_at);
        int idx = 0;
        int spent = 0;
        bit acc;
        while (idx < n && spent < 400) begin
            case (mode)
                0: pix_valid = 1'b1;
                1: pix_valid = (spent % 2 == 0);
                default: pix_valid = ($urandom_range(0, 2) != 0);
            endcase
            pix_in  = pix[idx][7:0];
            start_a = (idx == mid_start_at);
            acc = pix_valid && (to_b ? b_pix_ready : a_pix_ready);
            @(posedge clk); #1;
            if (acc) idx++;
            spent++;
        end
        pix_valid = 1'b0;
        start_a   = 1'b0;
        chk("send_budget", 80'(idx), 80'(n));
    endtask

    task automatic wait_done(input bit to_b, input bit hold_start);
        int k = 0;
        if (hold_start) start_a = 1'b1;
        while (k < 50 && (to_b ? (b_done_cyc < 0) : (done_cyc_q.size() == 0))) begin
            @(posedge clk); #1;
            k++;
        end
        start_a = 1'b0;
        chk("done_timeout", 80'(k < 50), 80'(1));
    endtask

    // Model: every interior pixel (r,c) with r,c >= 2 closes a window made of
    // frame rows r-2..r and columns c-2..c, emitted in raster order.
    task automatic check_frame(input string tag);
        int k = 0;
        int t_last;
        logic [8:0][7:0] e;
        chk({tag, "_accepts"}, 80'(acc_cyc_q.size()), 80'(W*H));
        t_last = (acc_cyc_q.size() > 0) ? acc_cyc_q[$] : -100;
        chk({tag, "_wins"}, 80'(win_q.size()), 80'((W-2)*(H-2)));
        chk({tag, "_sums"}, 80'(sum_cyc_q.size()), 80'((W-2)*(H-2)));
        chk({tag, "_dones"}, 80'(done_cyc_q.size()), 80'(1));
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e[3*i+j] = pix[(r-2+i)*W + (c-2+j)][7:0];
                if (k < win_q.size()) begin
                    chk({tag, "_taps"}, 80'(win_q[k][103:32]), 80'(e));
                    chk({tag, "_row"}, 80'(win_q[k][31:16]), 80'(r));
                    chk({tag, "_col"}, 80'(win_q[k][15:0]), 80'(c));
                end
                if (k < sum_cyc_q.size() && k < win_cyc_q.size())
                    chk({tag, "_sum_lat"}, 80'(sum_cyc_q[k] - win_cyc_q[k]), 80'(L));
                k++;
            end
        end
        if (win_cyc_q.size() > 0)
            chk({tag, "_last_win_cyc"}, 80'(win_cyc_q[$] - t_last), 80'(1));
        if (done_cyc_q.size() > 0)
            chk({tag, "_done_cyc"}, 80'(done_cyc_q[0] - t_last), 80'(1 + L));
        chk({tag, "_glitch"}, 80'(glitch), 80'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_taps"}, 80'(a_taps), 80'(0));
        chk({tag, "_ctl"}, 80'({a_win_valid, a_sum_valid, a_busy, a_pix_ready, a_frame_done}), 80'(0));
        chk({tag, "_pos"}, 80'({a_win_row, a_win_col}), 80'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0][7:0] eb;
        #12;
        check_reset_outputs("reset");
        chk("reset_b", 80'({b_taps, b_win_valid, b_sum_valid, b_busy, b_pix_ready, b_frame_done}), 80'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Contiguous 1..16
        clear_mon(); fill_seq(0);
        start_frame(0);
        chk("busy_after_start", 80'(a_busy), 80'(1));
        send(0, 16, 0, -1);
        wait_done(0, 0);
        check_frame("contig");
        chk("idle_after_done", 80'(a_busy), 80'(0));

        // Alternating valid; start held through drain must not restart
        clear_mon(); fill_seq(0);
        start_frame(0);
        send(0, 16, 1, -1);
        wait_done(0, 1);
        check_frame("gaps");
        @(posedge clk); #1;
        chk("start_at_done_ignored", 80'(a_busy), 80'(0));

        // pix_valid in IDLE without start
        clear_mon();
        pix_valid = 1'b1; pix_in = 8'hAA;
        repeat (5) begin @(posedge clk); #1; end
        chk("idle_ready", 80'({a_pix_ready, a_busy}), 80'(0));
        chk("idle_accepts", 80'(acc_cyc_q.size()), 80'(0));
        pix_valid = 1'b0;

        // Second start mid-frame is ignored
        clear_mon(); fill_seq(0);
        start_frame(0);
        send(0, 16, 0, 6);
        wait_done(0, 0);
        check_frame("midstart");

        // Reset after pixel 10, then a clean frame
        clear_mon(); fill_seq(0);
        start_frame(0);
        send(0, 10, 0, -1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
        start_frame(0);
        send(0, 16, 0, -1);
        wait_done(0, 0);
        check_frame("postrst");

        // Random pixels and random gaps
        for (int f = 0; f < 2; f++) begin
            clear_mon(); fill_rand();
            start_frame(0);
            send(0, 16, 2, -1);
            wait_done(0, 0);
            check_frame("rand");
        end

        // Back-to-back: start issued the cycle after frame_done
        clear_mon(); fill_seq(100);
        start_frame(0);
        send(0, 16, 0, -1);
        wait_done(0, 0);
        check_frame("b2b");

        // 3x3 image: a single window
        fill_seq(0);
        start_frame(1);
        send(1, 9, 0, -1);
        wait_done(1, 0);
        for (int i = 0; i < 9; i++) eb[i] = 8'(i + 1);
        chk("b_wins", 80'(b_wins), 80'(1));
        chk("b_taps", 80'(b_taps_cap), 80'(eb));
        chk("b_win_cyc", 80'(b_win_cyc - b_acc_last), 80'(1));
        chk("b_done_cyc", 80'(b_done_cyc - b_acc_last), 80'(3));
        chk("b_sum", 80'({b_sums, b_sum_cyc - b_done_cyc}), 80'({32'd1, 32'd0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
